word_insert_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational character shifter. It shifts a character-packed word left or right by a runtime character count and inserts it into a template word, producing the result length and a truncation flag. It uses valid/ready handshakes on both sides and sits in pkt_comm between the word-list/template stage and the word generator, sustaining one word per clock.

---
 rtl/word_insert_pipe_pkg.sv | 22 ++
 rtl/word_shift_lr.sv | 52 +++++
 rtl/word_insert_pipe.sv | 167 ++++++++++++++++
 tb/tb_word_insert_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_insert_pipe_pkg.sv
// Shared definitions for the word-insert pipeline. This file provides the
// width-derivation macro, the shift-direction encoding and a char-slice helper.
`ifndef MSB
`define MSB(x) $clog2((x) + 1)
`endif

package word_insert_pipe_pkg;

  localparam int DEF_CHAR_BITS    = 7;
  localparam int DEF_WORD_MAX_LEN = 8;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Bit offset of character k inside a packed word.
  function automatic int char_lsb(input int k, input int char_bits);
    return k * char_bits;
  endfunction

endpackage

// File: rtl/word_shift_lr.sv
// Combinational left/right character shifter with insert-mask generation.
// Source characters at or above len are zeroed before shifting, so garbage
// above the valid length can never reach the output.
module word_shift_lr
  import word_insert_pipe_pkg::*;
#(
  parameter int CHAR_BITS    = DEF_CHAR_BITS,
  parameter int WORD_MAX_LEN = DEF_WORD_MAX_LEN,
  parameter int LEN_W        = `MSB(WORD_MAX_LEN),
  parameter int POS_W        = `MSB(WORD_MAX_LEN - 1)
) (
  input  logic [WORD_MAX_LEN*CHAR_BITS-1:0] din,
  input  logic [LEN_W-1:0]                  len,
  input  logic [POS_W-1:0]                  pos,
  input  logic                              dir,
  output logic [WORD_MAX_LEN*CHAR_BITS-1:0] shifted,
  output logic [WORD_MAX_LEN-1:0]           mask
);

  localparam int WB = WORD_MAX_LEN * CHAR_BITS;

  logic [WORD_MAX_LEN-1:0] len_mask;
  logic [WB-1:0]           src;

  // Mark the valid source characters and zero everything above them.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    len_mask = '0;
    src      = '0;
    for (int k = 0; k < WORD_MAX_LEN; k++) begin
      len_mask[k] = (k < int'(len));
      if (len_mask[k]) begin
        src[char_lsb(k, CHAR_BITS) +: CHAR_BITS] = din[char_lsb(k, CHAR_BITS) +: CHAR_BITS];
      end
    end
  end

  // Barrel-shift the masked word and the valid-char mask by pos characters.
  always_comb begin
    shifted = '0;
    mask    = '0;
    if (dir == DIR_RIGHT) begin
      shifted = src >> (int'(pos) * CHAR_BITS);
      mask    = len_mask >> pos;
    end else begin
      shifted = src << (int'(pos) * CHAR_BITS);
      mask    = len_mask << pos;
    end
  end

endmodule

// File: rtl/word_insert_pipe.sv
// Two-stage pipelined character shifter/inserter with valid/ready on both
// sides. S1 shifts, builds the insert mask and computes length/truncation;
// S2 merges the shifted word into the template and holds the result.
module word_insert_pipe
  import word_insert_pipe_pkg::*;
#(
  parameter int CHAR_BITS    = DEF_CHAR_BITS,
  parameter int WORD_MAX_LEN = DEF_WORD_MAX_LEN,
  parameter int LEN_W        = `MSB(WORD_MAX_LEN),
  parameter int POS_W        = `MSB(WORD_MAX_LEN - 1)
) (
  input  logic                              CLK,
  input  logic                              rst_n,
  input  logic [WORD_MAX_LEN*CHAR_BITS-1:0] din,
  input  logic [LEN_W-1:0]                  din_len,
  input  logic [POS_W-1:0]                  pos,
  input  logic                              dir,
  input  logic                              merge,
  input  logic [WORD_MAX_LEN*CHAR_BITS-1:0] tmpl,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [WORD_MAX_LEN*CHAR_BITS-1:0] dout,
  output logic [LEN_W-1:0]                  dout_len,
  output logic                              trunc,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam int WB = WORD_MAX_LEN * CHAR_BITS;
  // One extra bit so pos + len cannot wrap.
  localparam int AW = LEN_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WORD_MAX_LEN);
  localparam logic [AW-1:0]    MAX_LEN_A = AW'(WORD_MAX_LEN);

  // Handshake / advance
  logic s1_valid;
  logic s1_load;
  logic s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Input clamping
  logic [LEN_W-1:0] eff_len;
  logic [POS_W-1:0] eff_pos;

  assign eff_len = (din_len > MAX_LEN) ? MAX_LEN : din_len;

  generate
    if ((2 ** POS_W) - 1 == WORD_MAX_LEN - 1) begin : g_pos_full
      assign eff_pos = pos;
    end else begin : g_pos_clamp
      localparam logic [POS_W-1:0] MAX_POS = POS_W'(WORD_MAX_LEN - 1);
      assign eff_pos = (pos > MAX_POS) ? MAX_POS : pos;
    end
  endgenerate

  // S1 combinational: shift, mask, length and truncation
  logic [WB-1:0]           sh_word;
  logic [WORD_MAX_LEN-1:0] sh_mask;

  word_shift_lr #(
    .CHAR_BITS    (CHAR_BITS),
    .WORD_MAX_LEN (WORD_MAX_LEN),
    .LEN_W        (LEN_W),
    .POS_W        (POS_W)
  ) u_shift (
    .din     (din),
    .len     (eff_len),
    .pos     (eff_pos),
    .dir     (dir),
    .shifted (sh_word),
    .mask    (sh_mask)
  );

  logic [AW-1:0]    len_a;
  logic [AW-1:0]    pos_a;
  logic [AW-1:0]    sum_a;
  logic [LEN_W-1:0] nx_len;
  logic             nx_trunc;

  assign len_a = AW'(eff_len);
  assign pos_a = AW'(eff_pos);
  assign sum_a = len_a + pos_a;

  // Result length and truncation for both shift directions.
  always_comb begin
    nx_len   = '0;
    nx_trunc = 1'b0;
    if (dir == DIR_RIGHT) begin
      nx_len   = (len_a > pos_a) ? LEN_W'(len_a - pos_a) : '0;
      nx_trunc = (pos_a != '0) && (len_a != '0);
    end else if (sum_a > MAX_LEN_A) begin
      nx_len   = MAX_LEN;
      nx_trunc = 1'b1;
    end else begin
      nx_len   = LEN_W'(sum_a);
    end
  end

  // S1 registers
  logic [WB-1:0]           s1_shift;
  logic [WORD_MAX_LEN-1:0] s1_mask;
  logic [WB-1:0]           s1_tmpl;
  logic                    s1_merge;
  logic [LEN_W-1:0]        s1_len;
  logic                    s1_trunc;

  // S1 register: capture a new word whenever S1 is empty or can hand off.
  always_ff @(posedge CLK or negedge rst_n) begin
    // NOTE: stage data is reset along with the valid flags because the
    // outputs must read zero during reset, not just be marked invalid.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_shift <= '0;
      s1_mask  <= '0;
      s1_tmpl  <= '0;
      s1_merge <= 1'b0;
      s1_len   <= '0;
      s1_trunc <= 1'b0;
    end else if (s1_load) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_shift <= sh_word;
        s1_mask  <= sh_mask;
        s1_tmpl  <= tmpl;
        s1_merge <= merge;
        s1_len   <= nx_len;
        s1_trunc <= nx_trunc;
      end
    end
  end

  // S2 combinational: widen the char mask and merge with the template
  logic [WB-1:0] mask_w;
  logic [WB-1:0] nx_dout;

  // Per-character select between shifted source, template and zero.
  always_comb begin
    mask_w = '0;
    for (int k = 0; k < WORD_MAX_LEN; k++) begin
      mask_w[char_lsb(k, CHAR_BITS) +: CHAR_BITS] = {CHAR_BITS{s1_mask[k]}};
    end
    nx_dout = (s1_shift & mask_w) | (s1_merge ? (s1_tmpl & ~mask_w) : '0);
  end

  // S2 output registers: hold while the consumer stalls.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      dout_len  <= '0;
      trunc     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        dout     <= nx_dout;
        dout_len <= s1_len;
        trunc    <= s1_trunc;
      end
    end
  end

endmodule

// File: tb/tb_word_insert_pipe.sv
// Self-checking bench for word_insert_pipe: directed cases with literal
// expectations, randomized streams against a character-index model, and
// asynchronous reset in the middle of a stalled pipeline.
module tb_word_insert_pipe;

  localparam int CB = 7;
  localparam int W  = 8;
  localparam int DW = W * CB;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [3:0]    len;
    logic          tr;
  } res_t;

  logic          CLK;
  logic          rst_n;
  logic [DW-1:0] din;
  logic [3:0]    din_len;
  logic [2:0]    pos;
  logic          dir;
  logic          merge;
  logic [DW-1:0] tmpl;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dout;
  logic [3:0]    dout_len;
  logic          trunc;
  logic          out_valid;
  logic          out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  word_insert_pipe dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .din       (din),
    .din_len   (din_len),
    .pos       (pos),
    .dir       (dir),
    .merge     (merge),
    .tmpl      (tmpl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .dout_len  (dout_len),
    .trunc     (trunc),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Character k of the string goes to char slot k; '.' means a zero char.
  function automatic logic [DW-1:0] pack(input string s);
    logic [DW-1:0] r;
    byte c;
    r = '0;
    for (int k = 0; k < s.len() && k < W; k++) begin
      c = s[k];
      r[k*CB +: CB] = (c == ".") ? 7'd0 : c[6:0];
    end
    return r;
  endfunction

  // Reference: compute the insert range from the rules, then fill each
  // output slot from its source index, the template or zero.
  function automatic res_t model(input logic [DW-1:0] d, input logic [3:0] dl,
                                 input logic [2:0] p, input logic dr,
                                 input logic m, input logic [DW-1:0] t);
    res_t r;
    int L, P, lo, hi, src;
    L = (int'(dl) > W) ? W : int'(dl);
    P = int'(p);
    if (P > W - 1) P = W - 1;
    if (!dr) begin
      lo   = P;
      hi   = (P + L > W) ? W : P + L;
      r.tr = (P + L > W);
    end else begin
      lo   = 0;
      hi   = (L - P > 0) ? L - P : 0;
      r.tr = (P > 0) && (L > 0);
    end
    r.len = 4'(hi);
    r.d   = '0;
    for (int j = 0; j < W; j++) begin
      if (j >= lo && j < hi) begin
        src = dr ? j + P : j - P;
        r.d[j*CB +: CB] = d[src*CB +: CB];
      end else if (m) begin
        r.d[j*CB +: CB] = t[j*CB +: CB];
      end
    end
    return r;
  endfunction

  task automatic randomize_inputs();
    din     = DW'({$urandom(), $urandom()});
    din_len = 4'($urandom_range(0, 15));
    pos     = 3'($urandom_range(0, 7));
    dir     = 1'($urandom_range(0, 1));
    merge   = 1'($urandom_range(0, 1));
    tmpl    = DW'({$urandom(), $urandom()});
  endtask

  // One word through an idle pipeline: accepted at one edge, result
  // visible after the following edge.
  task automatic run_one(input string tag, input logic [DW-1:0] d, input logic [3:0] dl,
                         input logic [2:0] p, input logic dr, input logic m,
                         input logic [DW-1:0] t, input res_t exp);
    @(negedge CLK);
    din = d; din_len = dl; pos = p; dir = dr; merge = m; tmpl = t;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(negedge CLK);
    in_valid = 1'b0;
    randomize_inputs();
    check({tag, "_not_yet"}, 64'(out_valid), 64'(0));
    @(negedge CLK);
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_dout"}, 64'(dout), 64'(exp.d));
    check({tag, "_len"}, 64'(dout_len), 64'(exp.len));
    check({tag, "_trunc"}, 64'(trunc), 64'(exp.tr));
  endtask

  // Stream n random words; bp selects random in_valid/out_ready.
  task automatic stream(input string tag, input int n, input bit bp);
    res_t q[$];
    res_t e;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [61:0] prev_out = '0;
    while ((sent < n || got < n) && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
      if (prev_stall)
        check({tag, "_stall_hold"}, 64'({out_valid, dout, dout_len, trunc}), 64'(prev_out));
      randomize_inputs();
      in_valid  = (sent < n) && (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check({tag, "_extra_output"}, 64'(q.size()), 64'(1));
        end else begin
          e = q.pop_front();
          check({tag, "_dout"}, 64'(dout), 64'(e.d));
          check({tag, "_len"}, 64'(dout_len), 64'(e.len));
          check({tag, "_trunc"}, 64'(trunc), 64'(e.tr));
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(din, din_len, pos, dir, merge, tmpl));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, dout, dout_len, trunc};
    end
    in_valid = 1'b0;
    check({tag, "_count"}, 64'(got), 64'(n));
    if (!bp) check({tag, "_throughput_cycles"}, 64'(cyc), 64'(n + 2));
    @(negedge CLK);
    check({tag, "_drained"}, 64'(out_valid), 64'(0));
  endtask

  res_t ex;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din = '0; din_len = '0; pos = '0; dir = 1'b0; merge = 1'b0; tmpl = '0;

    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_dout", 64'(dout), 64'(0));
    check("reset_len", 64'(dout_len), 64'(0));
    check("reset_trunc", 64'(trunc), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;

    ex = '{d: pack("XXabcXXX"), len: 4'd5, tr: 1'b0};
    run_one("left_basic", pack("abcQRSTU"), 4'd3, 3'd2, 1'b0, 1'b1, pack("XXXXXXXX"), ex);

    ex = '{d: pack(".....abc"), len: 4'd8, tr: 1'b1};
    run_one("left_overflow", pack("abcdefgh"), 4'd6, 3'd5, 1'b0, 1'b0, pack("XXXXXXXX"), ex);

    ex = '{d: pack("cdefZZZZ"), len: 4'd4, tr: 1'b1};
    run_one("right_basic", pack("abcdefgh"), 4'd6, 3'd2, 1'b1, 1'b1, pack("ZZZZZZZZ"), ex);

    ex = '{d: pack("ZZZZZZZZ"), len: 4'd0, tr: 1'b1};
    run_one("right_pos7", pack("abcdefgh"), 4'd6, 3'd7, 1'b1, 1'b1, pack("ZZZZZZZZ"), ex);

    ex = '{d: pack("PQRSTUVW"), len: 4'd3, tr: 1'b0};
    run_one("empty_left", pack("abcdefgh"), 4'd0, 3'd3, 1'b0, 1'b1, pack("PQRSTUVW"), ex);

    ex = '{d: pack("PQRSTUVW"), len: 4'd0, tr: 1'b0};
    run_one("empty_right", pack("abcdefgh"), 4'd0, 3'd3, 1'b1, 1'b1, pack("PQRSTUVW"), ex);

    ex = '{d: pack("abcdefgh"), len: 4'd8, tr: 1'b0};
    run_one("len_clamp", pack("abcdefgh"), 4'd15, 3'd0, 1'b0, 1'b0, pack("XXXXXXXX"), ex);

    ex = '{d: pack("abcd...."), len: 4'd4, tr: 1'b0};
    run_one("identity", pack("abcd...."), 4'd4, 3'd0, 1'b0, 1'b0, pack("XXXXXXXX"), ex);

    ex = '{d: pack("b......."), len: 4'd1, tr: 1'b1};
    run_one("garbage_right", pack("abcdefgh"), 4'd2, 3'd1, 1'b1, 1'b0, pack("XXXXXXXX"), ex);

    ex = '{d: pack(".abc...."), len: 4'd4, tr: 1'b0};
    run_one("garbage_left", pack("abcdefgh"), 4'd3, 3'd1, 1'b0, 1'b0, pack("XXXXXXXX"), ex);

    stream("bp_stream", 20, 1'b1);
    stream("full_rate", 12, 1'b0);

    // Fill both stages with the consumer stalled, then reset asynchronously.
    @(negedge CLK);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din = pack("aaaaaaaa"); din_len = 4'd8; pos = 3'd0; dir = 1'b0; merge = 1'b0;
    @(negedge CLK);
    din = pack("bbbbbbbb");
    @(negedge CLK);
    in_valid = 1'b0;
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_out_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_dout", 64'(dout), 64'(0));
    check("midrst_len", 64'(dout_len), 64'(0));
    check("midrst_trunc", 64'(trunc), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    @(negedge CLK);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge CLK);
    check("post_rst_empty", 64'(out_valid), 64'(0));

    ex = '{d: pack("..klm..."), len: 4'd5, tr: 1'b0};
    run_one("post_rst_word", pack("klmnopqr"), 4'd3, 3'd2, 1'b0, 1'b0, pack("XXXXXXXX"), ex);
    @(negedge CLK);
    check("post_rst_no_dup", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
